// File: rtl/oflow_calc_topk_min.sv
// oflow_calc_topk_min: keeps the K smallest lane scores (with IDs) seen since the last clear
module oflow_calc_topk_min #(
  parameter int SCORE_W = 16,
  parameter int ID_W = 12,
  parameter int NUM_LANES = 2,
  parameter int K = 4
) (
  input  logic                         clk,
  input  logic                         reset_N,
  input  logic                         start_score_calc,
  input  logic                         start_calc_min,
  input  logic [NUM_LANES-1:0]         lane_valid,
  input  logic [NUM_LANES*SCORE_W-1:0] score_in,
  input  logic [NUM_LANES*ID_W-1:0]    id_in,
  output logic                         busy,
  output logic                         done_calc_min,
  output logic [K*SCORE_W-1:0]         min_score,
  output logic [K*ID_W-1:0]            min_id,
  output logic [K-1:0]                 entry_valid,
  output logic [15:0]                  cand_count
);
  typedef enum logic [1:0] {IDLE, INSERT, DONE} state_t;
  state_t state, state_nxt;
  logic [NUM_LANES-1:0] mask_q, one_hot, mask_rest;
  logic [NUM_LANES*SCORE_W-1:0] score_q;
  logic [NUM_LANES*ID_W-1:0] id_q;
  logic [SCORE_W-1:0] cand_score;
  logic [ID_W-1:0] cand_id;
  logic [K-1:0] le, v_nxt;
  logic [SCORE_W-1:0] sc [K];
  logic [SCORE_W-1:0] sc_nxt [K];
  logic [ID_W-1:0] id [K];
  logic [ID_W-1:0] id_nxt [K];
  always_comb begin
    one_hot = mask_q & (~mask_q + NUM_LANES'(1));
    mask_rest = mask_q & ~one_hot;
    cand_score = '0;
    cand_id = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      cand_score = cand_score | (one_hot[l] ? score_q[l*SCORE_W +: SCORE_W] : '0);
      cand_id = cand_id | (one_hot[l] ? id_q[l*ID_W +: ID_W] : '0);
    end
    // valid entries are sorted and packed at the front, so le is a prefix mask
    for (int i = 0; i < K; i++) le[i] = entry_valid[i] && sc[i] <= cand_score;
    sc_nxt[0] = le[0] ? sc[0] : cand_score;
    id_nxt[0] = le[0] ? id[0] : cand_id;
    v_nxt[0] = le[0] ? entry_valid[0] : 1'b1;
    for (int i = 1; i < K; i++) begin
      sc_nxt[i] = le[i] ? sc[i] : le[i-1] ? cand_score : sc[i-1];
      id_nxt[i] = le[i] ? id[i] : le[i-1] ? cand_id : id[i-1];
      v_nxt[i] = le[i] ? entry_valid[i] : le[i-1] ? 1'b1 : entry_valid[i-1];
    end
    state_nxt = start_score_calc ? IDLE :
                state == IDLE ? (start_calc_min ? (|lane_valid ? INSERT : DONE) : IDLE) :
                state == INSERT ? (|mask_rest ? INSERT : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= IDLE;
      busy <= 1'b0;
      done_calc_min <= 1'b0;
      mask_q <= '0;
      score_q <= '0;
      id_q <= '0;
      entry_valid <= '0;
      cand_count <= '0;
      for (int i = 0; i < K; i++) begin
        sc[i] <= '1;
        id[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      busy <= state_nxt != IDLE;
      done_calc_min <= state_nxt == DONE;
      if (start_score_calc) begin
        mask_q <= '0;
        entry_valid <= '0;
        cand_count <= '0;
        for (int i = 0; i < K; i++) begin
          sc[i] <= '1;
          id[i] <= '0;
        end
      end else if (state == IDLE && start_calc_min) begin
        mask_q <= lane_valid;
        score_q <= score_in;
        id_q <= id_in;
      end else if (state == INSERT) begin
        mask_q <= mask_rest;
        sc <= sc_nxt;
        id <= id_nxt;
        entry_valid <= v_nxt;
        cand_count <= cand_count + 16'(cand_count != 16'hFFFF);
      end
    end
  end
  for (genvar g = 0; g < K; g++) begin : g_out
    assign min_score[g*SCORE_W +: SCORE_W] = sc[g];
    assign min_id[g*ID_W +: ID_W] = id[g];
  end
endmodule

// File: tb/tb_oflow_calc_topk_min.sv
// tb_oflow_calc_topk_min: directed checks of the top-K minimum tracker
module tb_oflow_calc_topk_min;
  logic clk = 0, reset_N = 0, start_score_calc = 0, start_calc_min = 0;
  logic [1:0] lane_valid = '0;
  logic [31:0] score_in = '0;
  logic [23:0] id_in = '0;
  logic busy, done_calc_min;
  logic [63:0] min_score;
  logic [47:0] min_id;
  logic [3:0] entry_valid;
  logic [15:0] cand_count;
  int total = 0, bad = 0;
  int lat, n;
  logic [63:0] snap;
  oflow_calc_topk_min dut (
    .clk(clk), .reset_N(reset_N), .start_score_calc(start_score_calc),
    .start_calc_min(start_calc_min), .lane_valid(lane_valid), .score_in(score_in),
    .id_in(id_in), .busy(busy), .done_calc_min(done_calc_min), .min_score(min_score),
    .min_id(min_id), .entry_valid(entry_valid), .cand_count(cand_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    start_score_calc = 1;
    tick();
    start_score_calc = 0;
  endtask
  task automatic round(input logic [1:0] m, input logic [15:0] s0, s1,
                       input logic [11:0] i0, i1, output int l);
    lane_valid = m;
    score_in = {s1, s0};
    id_in = {i1, i0};
    start_calc_min = 1;
    tick();
    start_calc_min = 0;
    lane_valid = '0;
    score_in = '0;
    id_in = '0;
    l = 1;
    while (!done_calc_min && l < 20) begin
      tick();
      l++;
    end
    tick();
  endtask
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_calc_min, 0);
    chk("rst_valid", entry_valid, 0);
    chk("rst_cnt", cand_count, 0);
    chk("rst_score", min_score, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_id", min_id, 0);
    reset_N = 1;
    tick();
    clear();
    round(2'b11, 16'd50, 16'd20, 12'd1, 12'd2, lat);
    chk("r1_lat", lat, 3);
    chk("r1_score", min_score[31:0], {16'd50, 16'd20});
    chk("r1_id", min_id[23:0], {12'd1, 12'd2});
    chk("r1_valid", entry_valid, 4'b0011);
    chk("r1_cnt", cand_count, 2);
    clear();
    round(2'b11, 16'd10, 16'd40, 12'd10, 12'd11, lat);
    round(2'b11, 16'd30, 16'd5, 12'd12, 12'd13, lat);
    round(2'b11, 16'd60, 16'd25, 12'd14, 12'd15, lat);
    chk("r3_score", min_score, {16'd30, 16'd25, 16'd10, 16'd5});
    chk("r3_id", min_id, {12'd12, 12'd15, 12'd10, 12'd13});
    chk("r3_valid", entry_valid, 4'b1111);
    chk("r3_cnt", cand_count, 6);
    clear();
    round(2'b01, 16'd7, 16'd0, 12'd3, 12'd0, lat);
    round(2'b10, 16'd0, 16'd7, 12'd0, 12'd9, lat);
    chk("tie_lat", lat, 2);
    chk("tie_id", min_id[23:0], {12'd9, 12'd3});
    round(2'b01, 16'hFFFF, 16'd0, 12'd5, 12'd0, lat);
    chk("ones_valid", entry_valid, 4'b0111);
    chk("ones_score", min_score[47:32], 16'hFFFF);
    chk("ones_id", min_id[35:24], 12'd5);
    snap = min_score;
    round(2'b00, 16'd1, 16'd1, 12'd7, 12'd7, lat);
    chk("empty_lat", lat, 1);
    chk("empty_list", min_score, snap);
    chk("empty_cnt", cand_count, 3);
    clear();
    lane_valid = 2'b11;
    score_in = {16'd8, 16'd9};
    id_in = {12'd1, 12'd2};
    start_calc_min = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        lane_valid = 2'b01;
        score_in = {16'd0, 16'd1};
      end
      if (done_calc_min) n++;
      if (i == 2) start_calc_min = 0;
    end
    chk("busy_done_n", n, 1);
    chk("busy_cnt", cand_count, 2);
    chk("busy_score", min_score[31:0], {16'd9, 16'd8});
    round(2'b11, 16'd4, 16'd3, 12'd1, 12'd2, lat);
    clear();
    lane_valid = 2'b11;
    score_in = {16'd4, 16'd3};
    start_calc_min = 1;
    tick();
    start_calc_min = 0;
    start_score_calc = 1;
    tick();
    start_score_calc = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", entry_valid, 0);
    chk("abort_cnt", cand_count, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_calc_min) n++;
      tick();
    end
    chk("abort_done_n", n, 0);
    round(2'b11, 16'd50, 16'd20, 12'd1, 12'd2, lat);
    lane_valid = 2'b11;
    score_in = {16'd6, 16'd2};
    start_calc_min = 1;
    tick();
    start_calc_min = 0;
    reset_N = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", entry_valid, 0);
    chk("arst_cnt", cand_count, 0);
    chk("arst_score", min_score, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("arst_id", min_id, 0);
    #2;
    reset_N = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_calc_min || busy) n++;
    end
    chk("arst_done_n", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oflow_calc_topk_min.md
OFLOW_CALC_TOPK_MIN -- requirements
Module: oflow_calc_topk_min

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, score width in bits.
REQ-002 SHALL have parameter ID_W, default 12, candidate ID width in bits.
REQ-003 SHALL have parameter NUM_LANES, default 2, number of similarity-metric lanes (1..8).
REQ-004 SHALL have parameter K, default 4, number of minima tracked (1..8).
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_score_calc  input  1  clear pulse; empties the list.
REQ-008 SHALL have port start_calc_min  input  1  round-start pulse.
REQ-009 SHALL have port lane_valid  input  NUM_LANES  per-lane candidate-present mask.
REQ-010 SHALL have port score_in  input  NUM_LANES*SCORE_W  packed lane scores, lane 0 in the LSBs.
REQ-011 SHALL have port id_in  input  NUM_LANES*ID_W  packed lane IDs, lane 0 in the LSBs.
REQ-012 SHALL have port busy  output  1  high while a round is in progress.
REQ-013 SHALL have port done_calc_min  output  1  one-cycle round-complete pulse.
REQ-014 SHALL have port min_score  output  K*SCORE_W  sorted scores; entry 0 is the smallest.
REQ-015 SHALL have port min_id  output  K*ID_W  IDs matching min_score.
REQ-016 SHALL have port entry_valid  output  K  entry-occupied flags.
REQ-017 SHALL have port cand_count  output  16  candidates inserted since the last clear, saturating at 0xFFFF.

Function
REQ-018 SHALL implement FSM states IDLE, INSERT and DONE.
REQ-019 SHALL, in IDLE with start_calc_min=1, capture lane_valid, score_in and id_in into internal registers and move to INSERT; inputs need not be held afterwards.
REQ-020 SHALL, in INSERT, process one captured valid lane per cycle in ascending lane index, skipping invalid lanes at zero cycle cost.
REQ-021 SHALL, when the captured mask is all-zero, go directly from IDLE to DONE.
REQ-022 SHALL move from INSERT to DONE after the last valid lane, then return to IDLE, asserting done_calc_min for exactly the DONE cycle; latency from start pulse to done = popcount(mask)+1 cycles.
REQ-023 SHALL assert busy in INSERT and DONE, and SHALL ignore start_calc_min while busy.
REQ-024 SHALL insert a candidate at position p = number of valid entries with score <= candidate score, so ties keep the earlier entry first.
REQ-025 SHALL shift entries p..K-2 down by one and drop entry K-1.
REQ-026 SHALL discard the candidate when p = K, leaving the list unchanged.
REQ-027 SHALL rank invalid entries after all valid entries; a score of all-ones is a legal candidate.
REQ-028 SHALL increment cand_count once per processed valid lane, whether kept or discarded, saturating at 0xFFFF.
REQ-029 SHALL have outputs driven directly from registers with no combinational path from inputs.
REQ-030 SHALL, on start_score_calc (any state, priority over all else), set all entries to score all-ones, ID 0, entry_valid 0, set cand_count to 0, abort any round to IDLE, and suppress done for it.
REQ-031 SHALL, when start_score_calc and start_calc_min coincide, perform the clear and not start a round.

Reset
REQ-032 SHALL, on reset_N=0, immediately set state IDLE, busy 0, done_calc_min 0, min_score all-ones, min_id 0, entry_valid 0, cand_count 0.
REQ-033 SHALL discard a round in progress when reset is asserted mid-round, with no done pulse after release.

Verification
REQ-034 SHALL verify: clear; then a round with scores {lane0=50, lane1=20} -> done 3 cycles after start; list [20,50], entry_valid=0b0011, cand_count=2.
REQ-035 SHALL verify: three rounds with scores {10,40},{30,5},{60,25} (K=4) -> list [5,10,25,30] with matching IDs; 40 and 60 evicted or discarded; cand_count=6.
REQ-036 SHALL verify: a tie where an entry holds score 7 with id 3 and a new score 7 with id 9 arrives -> id 3 at a lower index than id 9.
REQ-037 SHALL verify: lane_valid=0 -> done exactly 1 cycle after start, list unchanged; a start pulse while busy -> ignored, exactly one done pulse.
REQ-038 SHALL verify: start_score_calc in the cycle after start_calc_min -> no done pulse, entry_valid=0, cand_count=0, busy=0 the next cycle.
REQ-039 SHALL verify: reset_N low mid-round -> all outputs at reset values asynchronously; no done after release.
